// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory access controller: access sizes,
// controller FSM states and the default memory depth.
package mem_access_pkg;

  localparam int DEPTH_DEF = 32;
  localparam int DATA_W    = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RDW  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extract and extend a load lane, and merge
// store data into the selected lane of a read word.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (offset)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h  = offset[1] ? rdata[31:16] : rdata[15:0];
    ld_data = rdata;
    st_data = rdata;
    case (size_e'(size))
      SZ_BYTE: begin
        ld_data = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
        case (offset)
          2'd0:    st_data[7:0]   = wdata[7:0];
          2'd1:    st_data[15:8]  = wdata[7:0];
          2'd2:    st_data[23:16] = wdata[7:0];
          default: st_data[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        ld_data = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
        if (offset[1]) st_data[31:16] = wdata[15:0];
        else           st_data[15:0]  = wdata[15:0];
      end
      default: begin
        ld_data = rdata;
        st_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a word-indexed data memory: alignment/range check,
// sub-word loads with extension, sub-word stores as read-modify-write.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_read,
  input  logic [31:0] mem_data
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_e              state_q, state_d;
  logic                write_q, write_d, uns_q, uns_d;
  logic [1:0]          size_q, size_d, off_q, off_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d, mem_we_q, mem_we_d, mem_read_q, mem_read_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d, mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d, ld_data, st_data;
  logic                accept, req_err, word_store;

  assign accept     = req_valid && req_ready_q;
  assign word_store = req_write && (size_e'(req_size) == SZ_WORD);

  always_comb begin
    case (size_e'(req_size))
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= DEPTH_W) req_err = 1'b1;
  end

  mem_lane_align u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .offset      (off_q),
    .rdata       (mem_data),
    .wdata       (wdata_q),
    .ld_data     (ld_data),
    .st_data     (st_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = req_err ? S_RESP : (word_store ? S_WR : S_RD);
      S_RD:   state_d = S_RDW;
      S_RDW:  state_d = write_q ? S_WR : S_RESP;
      S_WR:   state_d = S_RESP;
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is registered, so each one is set on the edge entering the
  // state that owns it; strobes default low so they last exactly one cycle.
  always_comb begin
    write_d      = write_q;
    uns_d        = uns_q;
    size_d       = size_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    mem_read_d   = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        write_d      = req_write;
        uns_d        = req_unsigned;
        size_d       = req_size;
        off_d        = req_addr[1:0];
        wdata_d      = req_wdata;
        mem_addr_d   = {2'b00, req_addr[31:2]};
        req_ready_d  = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = req_err;
        if (req_err) resp_valid_d = 1'b1;
        else if (word_store) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = req_wdata;
        end else mem_read_d = 1'b1;
      end
      S_RDW: begin
        if (write_q) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = st_data;
        end else begin
          resp_rdata_d = ld_data;
          resp_valid_d = 1'b1;
        end
      end
      S_WR: resp_valid_d = 1'b1;
      S_RESP: if (resp_ready) begin
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        req_ready_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q      <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_read_q   <= 1'b0;
    end else begin
      write_q      <= write_d;
      uns_q        <= uns_d;
      size_q       <= size_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_read_q   <= mem_read_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign mem_read   = mem_read_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed plan plus random accesses against a
// byte-array reference model of the memory.
module tb_mem_access_ctrl;

  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_data;
  logic        resp_valid, resp_ready, resp_err, mem_we, mem_read;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_read(mem_read), .mem_data(mem_data)
  );

  // Bus-side memory: data appears the cycle after a mem_read cycle.
  logic [31:0] mem        [DEPTH];
  logic [31:0] init_words [DEPTH];
  logic        preload, rd_en_q;
  logic [31:0] rd_data_q;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_words[i];
    end else if (mem_we && mem_addr < DEPTH) mem[mem_addr[AW-1:0]] <= mem_wdata;
    rd_en_q   <= mem_read;
    rd_data_q <= (mem_addr < DEPTH) ? mem[mem_addr[AW-1:0]] : 32'hxxxxxxxx;
  end

  assign mem_data = rd_en_q ? rd_data_q : 32'bz;

  // Reference model: memory as a flat byte array.
  logic [7:0] ref_bytes [DEPTH*4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_exec(input bit wr, input bit [1:0] sz, input bit uns,
                          input bit [31:0] a, input bit [31:0] wd,
                          output bit [31:0] rd, output bit er, output int lat,
                          output int nrd, output int nwe, output bit [31:0] wword);
    int n;
    longint v;
    rd = 0; wword = 0;
    n  = (sz == 2'd3) ? 0 : (1 << sz);
    er = (n == 0) || (a % n != 0) || (a / 4 >= DEPTH);
    if (er) begin
      lat = 1; nrd = 0; nwe = 0;
      return;
    end
    if (wr) begin
      for (int i = 0; i < n; i++) ref_bytes[a + i] = 8'((wd >> (8 * i)) & 32'hFF);
      for (int i = 0; i < 4; i++) wword = wword | (32'(ref_bytes[(a / 4) * 4 + i]) << (8 * i));
      lat = (n == 4) ? 2 : 4;
      nrd = (n == 4) ? 0 : 1;
      nwe = 1;
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(ref_bytes[a + i]) << (8 * i));
      if (!uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      rd  = v[31:0];
      lat = 3; nrd = 1; nwe = 0;
    end
  endtask

  task automatic do_req(input bit wr, input bit [1:0] sz, input bit uns,
                        input bit [31:0] a, input bit [31:0] wd, input int hold);
    bit [31:0] erd, eword, wdat;
    bit        eerr, both;
    int        elat, enrd, enwe, lat, nrd, nwe;
    ref_exec(wr, sz, uns, a, wd, erd, eerr, elat, enrd, enwe, eword);
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nrd = 0; nwe = 0; both = 0; wdat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (mem_read) nrd++;
      if (mem_we) begin nwe++; wdat = mem_wdata; end
      if (mem_read && mem_we) both = 1;
      if (resp_valid) lat = k;
    end
    chk("latency", lat, elat);
    chk("mem_read_cycles", nrd, enrd);
    chk("mem_we_cycles", nwe, enwe);
    chk("strobe_overlap", {31'd0, both}, 32'd0);
    chk("resp_rdata", resp_rdata, erd);
    chk("resp_err", {31'd0, resp_err}, {31'd0, eerr});
    if (!eerr) chk("mem_addr", mem_addr, {2'b00, a[31:2]});
    if (enwe != 0) chk("mem_wdata", wdat, eword);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h8; req_wdata = $urandom;
      @(negedge clk);
      chk("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("post_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("post_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
  endtask

  initial begin
    int  we_seen;
    bit [31:0] w;
    reset = 1'b1; preload = 1'b1;
    req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; resp_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      w = (i == 12) ? 32'h0000000F : $urandom;
      init_words[i] = w;
      for (int b = 0; b < 4; b++) ref_bytes[i * 4 + b] = 8'((w >> (8 * b)) & 32'hFF);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; preload = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    do_req(0, 2'd2, 0, 32'h30, 0, 0);

    // Reset landing in the RD cycle of a byte store must drop the store.
    @(negedge clk);
    req_write = 1; req_size = 2'd0; req_unsigned = 0; req_addr = 32'h31; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_rd", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("abort");
    we_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_we) we_seen++;
    end
    chk("abort_no_we", we_seen, 0);
    do_req(0, 2'd2, 0, 32'h30, 0, 0);

    do_req(1, 2'd0, 0, 32'h31, 32'h80, 0);
    do_req(0, 2'd2, 0, 32'h30, 0, 0);
    do_req(0, 2'd0, 0, 32'h31, 0, 0);
    do_req(0, 2'd0, 1, 32'h31, 0, 0);
    do_req(0, 2'd1, 0, 32'h30, 0, 0);

    do_req(0, 2'd2, 0, 32'h32, 0, 0);
    do_req(1, 2'd1, 0, 32'h01, 32'h1234, 0);
    do_req(1, 2'd2, 0, 32'h80, 32'h12345678, 0);
    do_req(0, 2'd3, 0, 32'h10, 0, 0);

    do_req(1, 2'd2, 0, 32'h04, 32'hDEADBEEF, 5);
    do_req(0, 2'd2, 0, 32'h04, 0, 0);

    for (int r = 0; r < 60; r++) begin
      bit [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 + 15));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the data-memory interface: accepts load/store requests from the CPU execute stage and drives the word-indexed data memory's address/writedata/writeenable/MemRead strobes.
- Converts byte addresses to word indices, performs byte/half/word loads with sign or zero extension, and does sub-word stores as read-modify-write.
- Checks alignment and range, then returns one response per request over a valid/ready handshake.

Parameters:
- DEPTH, 32, number of 32-bit words in the data memory; valid word index 0..DEPTH-1.
- DATA_W, 32, data width; fixed, not to be overridden.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half used for sub-word stores.
- resp_valid  out  1  response held until accepted.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out of range or illegal size.
- mem_addr  out  32  word index = req_addr[31:2].
- mem_wdata  out  32  write data to memory.
- mem_we  out  1  memory writeenable.
- mem_read  out  1  memory MemRead.
- mem_data  in  32  memory read data; valid in the cycle after a mem_read cycle, otherwise z.

Behaviour:
- Reset: state IDLE. req_ready=1. resp_valid=0, resp_err=0. resp_rdata=0, mem_addr=0, mem_wdata=0. mem_we=0, mem_read=0.
- Reset asserted mid-operation aborts at that edge: strobes drop, no write is issued, and the pending response is discarded.
- All outputs are registered. mem_we and mem_read are never high in the same cycle.
- FSM states: IDLE, RD, RDW, WR, RESP.
- IDLE: when req_valid && req_ready, latch the request.
  - Error (size 11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= DEPTH): go to RESP with resp_err=1 and no memory strobe.
  - Load, or byte/half store: go to RD.
  - Word store: go to WR.
- RD: mem_read=1 for exactly one cycle, then go to RDW.
- RDW: sample mem_data.
  - Load: extract the lane selected by addr[1:0] (byte) or addr[1] (half), extend, register into resp_rdata, go to RESP.
  - Sub-word store: merge req_wdata into the selected lane of mem_data, register into mem_wdata, go to WR.
- WR: mem_we=1 for exactly one cycle, then go to RESP.
- RESP: resp_valid=1 with resp_rdata and resp_err stable. When resp_ready, clear resp_valid and go to IDLE; req_ready rises the following cycle (no back-to-back accept in the same cycle).
- Latency, counting cycles after the accept edge until resp_valid is visible:
  - error: 1
  - word store: 2
  - load: 3
  - sub-word store: 4
- Byte lane ordering is little-endian (byte 0 = bits 7:0).
- A held resp_valid ignores req_valid entirely.

Decomposition:
- Shared package mem_access_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state encoding;
  - DEPTH default.
- Sub-module mem_lane_align (combinational) holds the load extract/extend and store merge logic, so it can be unit-tested separately.

Test Plan:
- Reset, then load word at 0x30 (memory word 12 preloaded with 0x0000000F) -> resp_rdata=0x0000000F, resp_err=0, resp_valid 3 cycles after accept; mem_read high exactly 1 cycle.
- Store byte 0x80 at 0x31, then load word 0x30 -> resp_rdata=0x0000800F. Store sequence is mem_read 1 cycle, then mem_we 1 cycle with mem_wdata=0x0000800F; store resp_valid 4 cycles after accept.
- From that state: load byte signed 0x31 -> 0xFFFFFF80; load byte unsigned 0x31 -> 0x00000080; load half signed 0x30 -> 0xFFFF800F.
- Word load at 0x32, half store at 0x01, word store at 0x80 (index 32), size 11 -> resp_err=1, resp_rdata=0, no mem_we/mem_read ever; resp 1 cycle after accept.
- Word store 0xDEADBEEF to 0x04 with resp_ready held low 5 cycles -> resp_valid stays high, req_ready stays 0; a later load of 0x04 returns 0xDEADBEEF.
- Assert reset in the RD cycle of a sub-word store -> mem_we never rises, outputs return to reset values next cycle, and word 12 still reads 0x0000000F.
